// File: rtl/bus_arbiter.sv
// Round-robin owner of the internal wishbone bus: grants whole cyc-high cycles to one master at a time.
// Optional stuck-slave timeout is compiled in with `define BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_MASTERS-1:0]                 m_wb_cyc_i,
  input  logic [NUM_MASTERS-1:0]                 m_wb_stb_i,
  input  logic [NUM_MASTERS-1:0]                 m_wb_we_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_wb_adr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wb_dat_i,
  output logic [DATA_WIDTH-1:0]                  m_wb_dat_o,
  output logic [NUM_MASTERS-1:0]                 m_wb_ack_o,
  output logic                                   wb_cyc_o,
  output logic                                   wb_stb_o,
  output logic                                   wb_we_o,
  output logic [ADDR_WIDTH-1:0]                  wb_adr_o,
  output logic [DATA_WIDTH-1:0]                  wb_dat_o,
  input  logic [DATA_WIDTH-1:0]                  wb_dat_i,
  input  logic                                   wb_ack_i,
  output logic [NUM_MASTERS-1:0]                 grant,
  output logic                                   timeout_flag
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state;
  logic [IW-1:0] owner;      // current owner while OWNED, previous owner while IDLE
  logic [IW-1:0] nxt_owner;
  logic [IW-1:0] cand;
  logic          nxt_found;
  logic          owned;
  logic          stb_sel;
  logic          to_hit;

  assign owned   = (state == OWNED);
  assign stb_sel = owned & m_wb_stb_i[owner];

  // Scan downward so the last hit is the first requester after owner.
  always_comb begin
    nxt_found = 1'b0;
    nxt_owner = owner;
    cand      = owner;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = IW'((int'(owner) + i) % NUM_MASTERS);
      if (m_wb_cyc_i[cand]) begin
        nxt_found = 1'b1;
        nxt_owner = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= IW'(NUM_MASTERS - 1);
      grant <= '0;
    end else begin
      case (state)
        IDLE: if (nxt_found) begin
          state <= OWNED;
          owner <= nxt_owner;
          grant <= NUM_MASTERS'(1) << nxt_owner;
        end
        OWNED: if (!m_wb_cyc_i[owner]) begin
          state <= IDLE;
          grant <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb_cyc_o   = owned & m_wb_cyc_i[owner] & ~to_hit;
  assign wb_stb_o   = stb_sel & ~to_hit;
  assign wb_we_o    = owned & m_wb_we_i[owner];
  assign wb_adr_o   = owned ? m_wb_adr_i[owner] : '0;
  assign wb_dat_o   = owned ? m_wb_dat_i[owner] : '0;
  assign m_wb_ack_o = (owned && (wb_ack_i || to_hit)) ? grant : '0;
  assign m_wb_dat_o = !owned ? '0 : (to_hit ? '1 : wb_dat_i);

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] to_cnt;

  // A genuine ack in the terminal cycle takes priority over the synthetic one.
  assign to_hit = stb_sel & ~wb_ack_i & (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (!stb_sel || wb_ack_i || to_hit) to_cnt <= '0;
      else                                to_cnt <= to_cnt + CW'(1);
      if (to_hit) timeout_flag <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit         = 1'b0;
  assign timeout_flag   = 1'b0;
`endif

endmodule
